// File: rtl/uart_pkt_tx.sv
// Packet sequencer ahead of the UART transmitter: frames a payload as
// HEADER, payload bytes MSB first, then an inverted 8-bit sum checksum.
module uart_pkt_tx #(
  parameter int          NUM_BYTES = 2,
  parameter logic [7:0]  HEADER    = 8'hAA
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   send,
  input  logic [8*NUM_BYTES-1:0] payload,
  input  logic                   tx_done,
  output logic                   trmt,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic                   pkt_done
);

  localparam int              IDX_W  = 4;
  localparam logic [IDX_W-1:0] NB_IDX = IDX_W'(NUM_BYTES);
  localparam int              PW     = 8 * NUM_BYTES;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_NEXT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             trmt_q, trmt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             pkt_done_q, pkt_done_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       acc_q, acc_d;
  logic [PW-1:0]    shreg_q, shreg_d;
  logic             last_q, last_d;

  function automatic logic [7:0] chk_byte(input logic [7:0] sum);
    return ~sum;
  endfunction

  // Next-state and output computation for the packet sequencer.
  always_comb begin
    state_d    = state_q;
    trmt_d     = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    pkt_done_d = 1'b0;
    idx_d      = idx_q;
    acc_d      = acc_q;
    shreg_d    = shreg_q;
    last_d     = last_q;
    case (state_q)
      S_IDLE: begin
        // The pkt_done cycle still belongs to the finished packet, so send is ignored there.
        if (send && !pkt_done_q) begin
          shreg_d   = payload;
          tx_data_d = HEADER;
          trmt_d    = 1'b1;
          busy_d    = 1'b1;
          idx_d     = {IDX_W{1'b0}};
          acc_d     = 8'h00;
          last_d    = 1'b0;
          state_d   = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // tx_done may still be high from the previous byte while trmt is asserted.
        if (!trmt_q && tx_done) begin
          if (last_q) begin
            busy_d     = 1'b0;
            pkt_done_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_NEXT;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_NEXT: begin
        if (idx_q < NB_IDX) begin
          tx_data_d = shreg_q[PW-1 -: 8];
          acc_d     = acc_q + shreg_q[PW-1 -: 8];
          idx_d     = idx_q + 4'd1;
          shreg_d   = shreg_q << 8;
        end else begin
          tx_data_d = chk_byte(acc_q);
          last_d    = 1'b1;
        end
        trmt_d  = 1'b1;
        state_d = S_WAIT;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      trmt_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
      idx_q      <= {IDX_W{1'b0}};
      acc_q      <= 8'h00;
      shreg_q    <= {PW{1'b0}};
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      trmt_q     <= trmt_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      pkt_done_q <= pkt_done_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
    end
  end

  assign trmt     = trmt_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign pkt_done = pkt_done_q;

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Randomized bench for uart_pkt_tx with a behavioural transmitter and a
// packet-level reference model of the expected byte stream.
module tb_uart_pkt_tx;

  localparam int NB = 2;

  logic          clk;
  logic          rst_n;
  logic          send;
  logic [8*NB-1:0] payload;
  logic          tx_done;
  logic          trmt;
  logic [7:0]    tx_data;
  logic          busy;
  logic          pkt_done;

  int errors;
  int checks;
  int wide_err;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_pkt_tx #(.NUM_BYTES(NB), .HEADER(8'hAA)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .send    (send),
    .payload (payload),
    .tx_done (tx_done),
    .trmt    (trmt),
    .tx_data (tx_data),
    .busy    (busy),
    .pkt_done(pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: records each byte, keeps tx_done high through the trmt
  // cycle, clears it on the following cycle, then raises it after a random delay.
  bit pend_clr;
  int dly;
  bit prev_trmt;
  initial begin
    tx_done   = 1'b0;
    pend_clr  = 1'b0;
    dly       = 0;
    prev_trmt = 1'b0;
    wide_err  = 0;
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_clr = 1'b0;
      dly      = 0;
    end else if (trmt) begin
      got_q.push_back(tx_data);
      if (prev_trmt) wide_err++;
      pend_clr = 1'b1;
    end else if (pend_clr) begin
      tx_done  = 1'b0;
      pend_clr = 1'b0;
      dly      = $urandom_range(1, 5);
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) tx_done = 1'b1;
    end
    prev_trmt = trmt;
  end

  task automatic build_exp(input logic [8*NB-1:0] pl);
    logic [7:0] s;
    exp_q.delete();
    exp_q.push_back(8'hAA);
    s = 8'h00;
    for (int i = NB - 1; i >= 0; i--) begin
      exp_q.push_back(pl[8*i +: 8]);
      s = s + pl[8*i +: 8];
    end
    exp_q.push_back(~s);
  endtask

  task automatic do_packet(input logic [8*NB-1:0] pl, input bit pre_sent, input bit noise,
                           input bit chain, input logic [8*NB-1:0] next_pl);
    int  n;
    int  busy_low;
    bit  seen;
    got_q.delete();
    build_exp(pl);
    if (!pre_sent) begin
      @(negedge clk);
      payload = pl;
      send    = 1'b1;
    end
    @(negedge clk);
    send = 1'b0;
    chk("first_trmt", {31'd0, trmt}, 32'd1);
    chk("first_byte", {24'd0, tx_data}, 32'h0000_00AA);
    if (noise) payload = 16'hABCD;
    busy_low = 0;
    seen     = 1'b0;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (pkt_done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) busy_low++;
      send = noise && ($urandom_range(0, 3) == 0);
    end
    chk("pkt_done_seen", {31'd0, seen}, 32'd1);
    chk("busy_held", busy_low, 0);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("byte_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("byte%0d", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    end
    if (chain) begin
      send    = 1'b1;
      payload = next_pl;
      @(negedge clk);
      chk("send_in_done_ignored", {31'd0, trmt}, 32'd0);
      chk("pkt_done_width", {31'd0, pkt_done}, 32'd0);
    end else begin
      send = 1'b0;
    end
  endtask

  initial begin
    logic [8*NB-1:0] r;
    int n;
    bit seen;
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    send    = 1'b0;
    payload = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_trmt", {31'd0, trmt}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_packet(16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000);
    r = 16'($urandom_range(0, 65535));
    do_packet(16'hFF02, 1'b0, 1'b0, 1'b1, r);
    do_packet(r, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      r = 16'($urandom_range(0, 65535));
      do_packet(r, 1'b0, bit'($urandom_range(0, 1)), 1'b0, 16'h0000);
    end

    // Mid-packet asynchronous reset after the second byte's trmt.
    got_q.delete();
    @(negedge clk);
    payload = 16'h1234;
    send    = 1'b1;
    @(negedge clk);
    send = 1'b0;
    seen = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      #1;
      if (got_q.size() >= 2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("second_byte_seen", {31'd0, seen}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_trmt", {31'd0, trmt}, 32'd0);
    chk("arst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_pkt_done", {31'd0, pkt_done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("no_resume_bytes", got_q.size(), 2);
    chk("no_resume_busy", {31'd0, busy}, 32'd0);

    do_packet(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("trmt_width", wide_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
